// File: rtl/fifo_ram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : fifo_ram_ctrl
// Description : FIFO controller for an external same-clock RAM with a small
//               credit-managed output buffer that hides RAM read latency.
//               Optional macro FIFO_RAM_CTRL_ERR_EN adds a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ram_ctrl #(
    parameter int DEPTH        = 512,
    parameter int ADDR_WIDTH   = 9,
    parameter int DATA_WIDTH   = 8,
    parameter int OUTPUT_REG   = 1,
    parameter int AFULL_THRESH = 496
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  wr_afull,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH+2:0] count,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_re,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef FIFO_RAM_CTRL_ERR_EN
    ,
    output logic                  wr_overflow,
    input  logic                  err_clr
`endif
);

    localparam int c_lat   = 1 + OUTPUT_REG;
    localparam int c_buf_n = c_lat + 1;
    localparam int c_iw    = $clog2(c_buf_n);
    localparam int c_cw    = $clog2(c_buf_n + 1);
    localparam int c_pw    = ADDR_WIDTH + 1;
    localparam int c_ow    = ADDR_WIDTH + 3;
    localparam logic [c_pw-1:0] c_depth = c_pw'(DEPTH);
    localparam logic [c_pw-1:0] c_afull = c_pw'(AFULL_THRESH);
    localparam logic [c_iw-1:0] c_last  = c_iw'(c_buf_n - 1);
    localparam logic [c_cw:0]   c_slots = (c_cw + 1)'(c_buf_n);

    logic [c_pw-1:0]       r_wptr;
    logic [c_pw-1:0]       r_rptr;
    logic [c_lat-1:0]      r_sr;
    logic [DATA_WIDTH-1:0] r_buf [c_buf_n];
    logic [c_iw-1:0]       r_head;
    logic [c_iw-1:0]       r_tail;
    logic [c_cw-1:0]       r_buf_cnt;

    logic [c_pw-1:0]       w_ram_occ;
    logic [c_cw-1:0]       w_inflight;
    logic                  w_push;
    logic                  w_pop;
    logic [c_cw:0]         w_used;
    logic [c_cw:0]         w_limit;

    function automatic logic [c_iw-1:0] f_inc(input logic [c_iw-1:0] idx);
        f_inc = (idx == c_last) ? '0 : idx + c_iw'(1);
    endfunction

    // Occupancy from registered pointers only, so a word is never read in its write cycle.
    assign w_ram_occ = r_wptr - r_rptr;
    assign wr_full   = (w_ram_occ == c_depth);
    assign wr_afull  = (w_ram_occ >= c_afull);

    assign ram_we    = wr_en & ~wr_full;
    assign ram_waddr = r_wptr[ADDR_WIDTH-1:0];
    assign ram_wdata = wr_data;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < c_lat; i++) begin
            w_inflight = w_inflight + c_cw'(r_sr[i]);
        end
    end

    assign w_push   = r_sr[c_lat-1];
    assign rd_valid = (r_buf_cnt != '0);
    assign rd_data  = r_buf[r_head];
    assign w_pop    = rd_valid & rd_ready;

    // A pop in this cycle frees a slot, which keeps a full-rate stream bubble-free.
    assign w_used    = {1'b0, r_buf_cnt} + {1'b0, w_inflight};
    assign w_limit   = c_slots + {{c_cw{1'b0}}, w_pop};
    assign ram_re    = (w_ram_occ != '0) && (w_used < w_limit);
    assign ram_raddr = r_rptr[ADDR_WIDTH-1:0];

    assign count = c_ow'(w_ram_occ) + c_ow'(w_inflight) + c_ow'(r_buf_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_sr      <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_buf_cnt <= '0;
        end else begin
            if (ram_we) begin
                r_wptr <= r_wptr + c_pw'(1);
            end
            if (ram_re) begin
                r_rptr <= r_rptr + c_pw'(1);
            end
            r_sr[0] <= ram_re;
            for (int i = 1; i < c_lat; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
            if (w_push) begin
                r_tail <= f_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= f_inc(r_head);
            end
            if (w_push && !w_pop) begin
                r_buf_cnt <= r_buf_cnt + c_cw'(1);
            end else if (!w_push && w_pop) begin
                r_buf_cnt <= r_buf_cnt - c_cw'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_tail] <= ram_rdata;
        end
    end

`ifdef FIFO_RAM_CTRL_ERR_EN
    logic r_overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (wr_en && wr_full) begin
            r_overflow <= 1'b1;
        end else if (err_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign wr_overflow = r_overflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ram_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ram_ctrl
// Description : Directed self-checking bench for fifo_ram_ctrl with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ram_ctrl;

    localparam int DEPTH        = 512;
    localparam int AW           = 9;
    localparam int DW           = 8;
    localparam int LAT          = 2;
    localparam int AFULL        = 496;
    localparam int FULL_WORDS   = DEPTH + LAT + 1;
    localparam int STREAM_WORDS = 2 * DEPTH + 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          wr_full;
    logic          wr_afull;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready;
    logic [AW+2:0] count;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic [DW-1:0] ram_rdata;
`ifdef FIFO_RAM_CTRL_ERR_EN
    logic          wr_overflow;
    logic          err_clr;
`endif

    int            n_tests = 0;
    int            n_fail  = 0;
    int            tx;
    int            rx;
    int            bubbles;
    bit            started;
    bit            prev_stall;
    bit            saw_valid;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] q[$];

    always #5 clk = ~clk;

    fifo_ram_ctrl #(
        .DEPTH        (DEPTH),
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .OUTPUT_REG   (1),
        .AFULL_THRESH (AFULL)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .wr_afull  (wr_afull),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .count     (count),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata)
`ifdef FIFO_RAM_CTRL_ERR_EN
        ,
        .wr_overflow (wr_overflow),
        .err_clr     (err_clr)
`endif
    );

    // Two-cycle read-latency RAM; deliberately not reset.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] r_s1;
    logic [DW-1:0] r_s2;

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) r_s1 <= mem[ram_raddr];
        r_s2 <= r_s1;
    end
    assign ram_rdata = r_s2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
`ifdef FIFO_RAM_CTRL_ERR_EN
        err_clr  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_wr_full", 32'(wr_full), 0);
        check("rst_wr_afull", 32'(wr_afull), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_re", 32'(ram_re), 0);
        check("rst_count", 32'(count), 0);
        check("rst_waddr", 32'(ram_waddr), 0);
        check("rst_raddr", 32'(ram_raddr), 0);
`ifdef FIFO_RAM_CTRL_ERR_EN
        check("rst_overflow", 32'(wr_overflow), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Single word latency: visible three edges after the write edge.
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h11; rd_ready = 1'b1; #1;
        check("lat_ram_we", 32'(ram_we), 1);
        check("lat_waddr", 32'(ram_waddr), 0);
        check("lat_wdata", 32'(ram_wdata), 'h11);
        @(negedge clk);
        wr_en = 1'b0; #1;
        check("lat_count_e0", 32'(count), 1);
        check("lat_ram_re", 32'(ram_re), 1);
        check("lat_valid_e0", 32'(rd_valid), 0);
        @(negedge clk); #1;
        check("lat_valid_e1", 32'(rd_valid), 0);
        check("lat_count_e1", 32'(count), 1);
        @(negedge clk); #1;
        check("lat_valid_e2", 32'(rd_valid), 0);
        @(negedge clk); #1;
        check("lat_valid_e3", 32'(rd_valid), 1);
        check("lat_data", 32'(rd_data), 'h11);
        check("lat_count_e3", 32'(count), 1);
        @(negedge clk); #1;
        check("lat_valid_after_pop", 32'(rd_valid), 0);
        check("lat_count_after_pop", 32'(count), 0);

        // Fill to full with the output stalled.
        rd_ready = 1'b0;
        for (int k = 0; k < FULL_WORDS; k++) begin
            @(negedge clk); #1;
            if (k == AFULL + LAT) check("afull_below", 32'(wr_afull), 0);
            if (k == AFULL + LAT + 1) check("afull_at", 32'(wr_afull), 1);
            if (k == FULL_WORDS - 1) check("full_before_last", 32'(wr_full), 0);
            wr_en = 1'b1; wr_data = DW'(k);
        end
        @(negedge clk);
        wr_en = 1'b0; #1;
        check("full_flag", 32'(wr_full), 1);
        check("full_count", 32'(count), FULL_WORDS);
        check("full_re_blocked", 32'(ram_re), 0);
        wr_en = 1'b1; wr_data = 8'hEE; #1;
        check("full_drop_we", 32'(ram_we), 0);
        @(negedge clk);
        wr_en = 1'b0; #1;
        check("full_drop_count", 32'(count), FULL_WORDS);
`ifdef FIFO_RAM_CTRL_ERR_EN
        check("ovf_set", 32'(wr_overflow), 1);
        @(negedge clk); #1;
        check("ovf_sticky", 32'(wr_overflow), 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0; #1;
        check("ovf_clr", 32'(wr_overflow), 0);
`endif
        rx = 0;
        for (int c = 0; c < FULL_WORDS + 20 && rx < FULL_WORDS; c++) begin
            @(negedge clk);
            rd_ready = 1'b1; #1;
            if (rd_valid) begin
                check("drain_data", 32'(rd_data), rx & 'hFF);
                rx++;
            end
        end
        check("drain_words", rx, FULL_WORDS);
        @(negedge clk);
        rd_ready = 1'b0; #1;
        check("drain_count", 32'(count), 0);
        check("drain_valid", 32'(rd_valid), 0);

        // Full-rate stream across pointer wrap.
        tx = 0; rx = 0; bubbles = 0; started = 1'b0;
        for (int c = 0; c < STREAM_WORDS + 40 && rx < STREAM_WORDS; c++) begin
            @(negedge clk); #1;
            if (rd_valid) begin
                check("stream_data", 32'(rd_data), rx & 'hFF);
                rx++;
                started = 1'b1;
            end else if (started) begin
                bubbles++;
            end
            wr_en = (tx < STREAM_WORDS); wr_data = DW'(tx); rd_ready = 1'b1; #1;
            if (ram_we) tx++;
        end
        wr_en = 1'b0;
        check("stream_words", rx, STREAM_WORDS);
        check("stream_bubbles", bubbles, 0);

        // Random backpressure against a queue scoreboard.
        q.delete();
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            check("rand_count", 32'(count), q.size());
            if (prev_stall) begin
                check("stall_valid", 32'(rd_valid), 1);
                check("stall_data", 32'(rd_data), 32'(prev_data));
            end
            rd_ready = 1'($urandom_range(0, 1));
            wr_en    = ($urandom_range(0, 3) != 0);
            wr_data  = DW'($urandom);
            #1;
            if (rd_valid && rd_ready) begin
                if (q.size() == 0) begin
                    check("rand_extra_word", 1, 0);
                end else begin
                    check("rand_data", 32'(rd_data), 32'(q[0]));
                    void'(q.pop_front());
                end
            end
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (ram_we) q.push_back(wr_data);
        end
        for (int c = 0; c < 400 && q.size() != 0; c++) begin
            @(negedge clk);
            wr_en = 1'b0; rd_ready = 1'b1; #1;
            if (rd_valid) begin
                check("rand_drain_data", 32'(rd_data), 32'(q[0]));
                void'(q.pop_front());
            end
        end
        check("rand_drained", q.size(), 0);
        @(negedge clk); #1;
        check("rand_final_count", 32'(count), 0);

        // Asynchronous reset with words buffered and in flight.
        rd_ready = 1'b0;
        @(negedge clk); wr_en = 1'b1; wr_data = 8'hA1;
        @(negedge clk); wr_data = 8'hA2;
        @(negedge clk); wr_data = 8'hA3;
        @(negedge clk); wr_en = 1'b0; #1;
        check("inflight_count", 32'(count), 3);
        @(negedge clk); #1;
        check("inflight_count2", 32'(count), 3);
        check("inflight_valid", 32'(rd_valid), 1);
        #2;
        rst_n = 1'b0; #1;
        check("arst_rd_valid", 32'(rd_valid), 0);
        check("arst_count", 32'(count), 0);
        check("arst_ram_re", 32'(ram_re), 0);
        check("arst_wr_full", 32'(wr_full), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rd_ready = 1'b1; #1;
            if (rd_valid) saw_valid = 1'b1;
        end
        check("no_stale_word", 32'(saw_valid), 0);
        check("post_rst_count", 32'(count), 0);
        @(negedge clk); wr_en = 1'b1; wr_data = 8'h5A;
        @(negedge clk); wr_en = 1'b0;
        rx = 0;
        for (int c = 0; c < 10 && rx == 0; c++) begin
            @(negedge clk); #1;
            if (rd_valid) begin
                check("recover_data", 32'(rd_data), 'h5A);
                rx = 1;
            end
        end
        check("recover_seen", rx, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
